mult32x32_req_ctrl: RTL and testbench

Request/response front end that sits directly upstream of the 32x32 multiplier (FSM plus datapath). It accepts operand pairs on a valid/ready handshake and holds them stable on the multiplier operand inputs. It pulses start and tracks the busy window, then captures the 64-bit product into an output register with its own valid/ready handshake. It also checks the multiplier's busy protocol and reports violations through sticky error flags.

---
 rtl/mult32x32_req_ctrl_if.sv | 25 ++
 rtl/mult32x32_req_ctrl.sv | 132 +++++++++++++
 tb/tb_mult32x32_req_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult32x32_req_ctrl_if.sv
// Request and result handshake bundle between a requester and mult32x32_req_ctrl.
// The requester owns the master side and the controller owns the slave side.
interface mult32x32_req_ctrl_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_product;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_product, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_product, out_tag
   );
endinterface

// File: rtl/mult32x32_req_ctrl.sv
// Front end for the 32x32 multiplier: holds operands, issues start, watches the busy
// window and registers the product behind its own valid/ready slot.
module mult32x32_req_ctrl #(
   parameter int TAG_W       = 4,
   parameter int BUSY_CYCLES = 8,
   parameter int TIMEOUT     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   mult32x32_req_ctrl_if.slave   bus,
   output logic [31:0]           o_mult_a,
   output logic [31:0]           o_mult_b,
   output logic                  o_mult_start,
   input  logic                  i_mult_busy,
   input  logic [63:0]           i_mult_product,
   output logic                  o_err_timeout,
   output logic                  o_err_len
);
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RUN, S_STALL} state_t;

   localparam logic [7:0] TO_C  = 8'(TIMEOUT);
   localparam logic [7:0] LEN_C = 8'(BUSY_CYCLES);

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_cnt, w_cnt_nxt;
   logic [31:0]      r_a, r_b;
   logic [TAG_W-1:0] r_tag;
   logic             r_out_valid;
   logic [63:0]      r_out_product;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_err_to, r_err_len;

   logic w_accept, w_capture, w_set_to, w_set_len, w_slot_free;

   assign w_slot_free = !r_out_valid || bus.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_set_to    = 1'b0;
      w_set_len   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_mult_busy) begin
               w_cnt_nxt   = 8'd1;
               w_state_nxt = S_RUN;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
               if (r_cnt + 8'd1 == TO_C) begin
                  w_set_to    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_RUN: begin
            if (i_mult_busy) begin
               w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            end else begin
               w_set_len = (r_cnt != LEN_C);
               if (w_slot_free) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_STALL;
               end
            end
         end
         S_STALL: begin
            // Multiplier is idle here, so its product register is still valid.
            if (w_slot_free) begin
               w_capture   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= 8'd0;
         r_a           <= 32'd0;
         r_b           <= 32'd0;
         r_tag         <= '0;
         r_out_valid   <= 1'b0;
         r_out_product <= 64'd0;
         r_out_tag     <= '0;
         r_err_to      <= 1'b0;
         r_err_len     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_tag <= bus.in_tag;
         end
         if (w_set_to)  r_err_to  <= 1'b1;
         if (w_set_len) r_err_len <= 1'b1;
         if (w_capture) begin
            r_out_valid   <= 1'b1;
            r_out_product <= i_mult_product;
            r_out_tag     <= r_tag;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = (r_state == S_IDLE);
   assign bus.out_valid   = r_out_valid;
   assign bus.out_product = r_out_product;
   assign bus.out_tag     = r_out_tag;
   assign o_mult_a        = r_a;
   assign o_mult_b        = r_b;
   assign o_mult_start    = (r_state == S_LAUNCH);
   assign o_err_timeout   = r_err_to;
   assign o_err_len       = r_err_len;
endmodule

// File: tb/tb_mult32x32_req_ctrl.sv
// Randomized bench for mult32x32_req_ctrl: a behavioural multiplier with selectable busy
// length, and a result queue plus sticky-flag model as the reference.
module tb_mult32x32_req_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mult_a, mult_b;
   logic        mult_start, mult_busy;
   logic [63:0] mult_product;
   logic        err_timeout, err_len;

   mult32x32_req_ctrl_if #(.TAG_W(4)) bus ();

   mult32x32_req_ctrl #(.TAG_W(4), .BUSY_CYCLES(8), .TIMEOUT(4)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .bus            (bus),
      .o_mult_a       (mult_a),
      .o_mult_b       (mult_b),
      .o_mult_start   (mult_start),
      .i_mult_busy    (mult_busy),
      .i_mult_product (mult_product),
      .o_err_timeout  (err_timeout),
      .o_err_len      (err_len)
   );

   always #5 clk = ~clk;

   typedef struct {logic [63:0] p; logic [3:0] t;} exp_t;
   exp_t expq[$];
   int   n_chk = 0, n_err = 0;
   int   cur_len = 8;
   int   rmode = 1;
   bit   mon_en = 1'b0;
   bit   exp_to = 1'b0, exp_len = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Multiplier model: busy rises the cycle after start and stays high cur_len cycles.
   initial begin
      int busy_left;
      busy_left = 0;
      mult_busy = 1'b0;
      mult_product = 64'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_left = 0;
            mult_busy = 1'b0;
         end else begin
            mult_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (mult_start) begin
               busy_left    = cur_len;
               mult_product = {32'd0, mult_a} * {32'd0, mult_b};
            end
         end
      end
   end

   // Result monitor: drives out_ready, checks hold under backpressure, scores deliveries.
   initial begin
      bit          pv;
      logic [63:0] pp;
      logic [3:0]  pt;
      exp_t        e;
      pv = 1'b0; pp = '0; pt = '0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               chk("hold_valid", 64'(bus.out_valid), 64'd1);
               chk("hold_product", bus.out_product, pp);
               chk("hold_tag", 64'(bus.out_tag), 64'(pt));
            end
            bus.out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
            if (bus.out_valid && bus.out_ready) begin
               if (expq.size() == 0) begin
                  chk("spurious_result", 64'd1, 64'd0);
               end else begin
                  e = expq.pop_front();
                  chk("product", bus.out_product, e.p);
                  chk("tag", 64'(bus.out_tag), 64'(e.t));
               end
            end
            pv = bus.out_valid && !bus.out_ready;
            pp = bus.out_product;
            pt = bus.out_tag;
         end
      end
   end

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                           input int len);
      exp_t e;
      if (len == 0) begin
         exp_to = 1'b1;
      end else begin
         if (len != 8) exp_len = 1'b1;
         e.p = {32'd0, a} * {32'd0, b};
         e.t = tg;
         expq.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                       input int len);
      int n;
      n = 0;
      bus.in_a = a; bus.in_b = b; bus.in_tag = tg; bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
      cur_len = len;
      push_exp(a, b, tg, len);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || bus.out_valid || !bus.in_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_to));
      chk({tag, "_err_len"}, 64'(err_len), 64'(exp_len));
   endtask

   // Cycle-exact nominal timeline from accept (cycle t) to out_valid (t+11).
   task automatic latency(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg);
      bus.in_a = a; bus.in_b = b; bus.in_tag = tg; bus.in_valid = 1'b1;
      chk("lat_ready_t", 64'(bus.in_ready), 64'd1);
      cur_len = 8;
      push_exp(a, b, tg, 8);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
         chk($sformatf("lat_start_%0d", k), 64'(mult_start), 64'(k == 1));
         chk($sformatf("lat_in_ready_%0d", k), 64'(bus.in_ready), 64'(k == 11));
         chk($sformatf("lat_out_valid_%0d", k), 64'(bus.out_valid), 64'(k == 11));
      end
      chk("lat_product", bus.out_product, {32'd0, a} * {32'd0, b});
      chk("lat_tag", 64'(bus.out_tag), 64'(tg));
      drain();
   endtask

   initial begin
      int lens[6] = '{8, 8, 8, 7, 9, 0};
      int n;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_start", 64'(mult_start), 64'd0);
      chk("rst_mult_a", 64'(mult_a), 64'd0);
      chk("rst_out_product", bus.out_product, 64'd0);
      chk_flags("rst");
      reset = 1'b0;
      rmode = 1;
      mon_en = 1'b1;
      @(negedge clk);

      latency(32'h3, 32'h5, 4'h1);
      chk_flags("lat1");
      latency(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);

      // Backpressure: second result waits in STALL behind an unconsumed first one.
      rmode = 0;
      send(32'd9, 32'd9, 4'h3, 8);
      n = 0;
      while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
      chk("bp_first_valid", 64'(bus.out_valid), 64'd1);
      send(32'd2, 32'd7, 4'h4, 8);
      repeat (15) @(negedge clk);
      chk("bp_stall_product", bus.out_product, 64'd81);
      chk("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
      rmode = 1;
      drain();
      chk_flags("bp");

      // Busy never rises: abandoned after the 4th WAIT cycle.
      bus.in_a = 32'd11; bus.in_b = 32'd13; bus.in_tag = 4'h5; bus.in_valid = 1'b1;
      cur_len = 0;
      push_exp(32'd11, 32'd13, 4'h5, 0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
         chk($sformatf("to_flag_%0d", k), 64'(err_timeout), 64'(k == 6));
         chk($sformatf("to_in_ready_%0d", k), 64'(bus.in_ready), 64'(k == 6));
         chk($sformatf("to_out_valid_%0d", k), 64'(bus.out_valid), 64'd0);
      end
      send(32'd6, 32'd7, 4'h6, 8);
      drain();
      chk_flags("after_to");

      send(32'h1234_5678, 32'd16, 4'h7, 7);
      drain();
      chk_flags("short_busy");

      rmode = 2;
      for (int i = 0; i < 40; i++) begin
         send($urandom, $urandom, 4'($urandom_range(0, 15)), lens[$urandom_range(0, 5)]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rmode = 1;
      drain();
      chk_flags("random");

      // Reset during RUN drops the operation and clears the sticky flags.
      send(32'd100, 32'd200, 4'h8, 8);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b0;
      expq.delete();
      exp_to = 1'b0;
      exp_len = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_start", 64'(mult_start), 64'd0);
      chk_flags("midrst");
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      send(32'hDEAD_BEEF, 32'd3, 4'h9, 8);
      drain();
      chk_flags("final");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
